// File: rtl/e203_csr_vec_pkg.sv
// Shared types and helpers for the trap-vector CSR bank: mode encoding, entry layout,
// and the one-hot select check.
package e203_csr_vec_pkg;

    localparam int unsigned CSR_XLEN    = 32;
    localparam int unsigned CSR_SEL_MAX = 8;

    typedef enum logic [1:0] {
        MODE_DIRECT   = 2'd0,
        MODE_VECTORED = 2'd1
    } vec_mode_e;

    typedef struct packed {
        logic [CSR_XLEN-1:0] base;
        vec_mode_e           mode;
        logic                locked;
    } vec_entry_t;

    function automatic logic is_onehot(input logic [CSR_SEL_MAX-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < CSR_SEL_MAX; i++) begin
            cnt = cnt + {31'b0, vec[i]};
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/e203_csr_vec_entry.sv
// One trap-vector entry: aligned base, WARL mode field and a sticky lock bit.
module e203_csr_vec_entry
    import e203_csr_vec_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     BASE_LSB = 6,
    parameter logic [XLEN-1:0] RST_BASE = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_wr_en,
    input  logic            i_lock_req,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_base,
    output logic [1:0]      o_mode,
    output logic            o_locked
);

    localparam logic [XLEN-1:0] BASE_MASK = ~((XLEN'(1) << BASE_LSB) - XLEN'(1));

    vec_entry_t r_entry;
    vec_entry_t w_entry_nxt;

    always_comb begin
        w_entry_nxt = r_entry;
        if (i_wr_en) begin
            w_entry_nxt.base = i_wdata & BASE_MASK;
            // Only encodings 0 and 1 are legal; 2 and 3 keep the previous mode.
            if (!i_wdata[1]) begin
                w_entry_nxt.mode = vec_mode_e'(i_wdata[1:0]);
            end
            w_entry_nxt.locked = r_entry.locked | i_lock_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '{base: RST_BASE & BASE_MASK, mode: MODE_DIRECT, locked: 1'b0};
        end else begin
            r_entry <= w_entry_nxt;
        end
    end

    assign o_base   = r_entry.base;
    assign o_mode   = r_entry.mode;
    assign o_locked = r_entry.locked;

endmodule

// File: rtl/e203_exu_csr_vec_bank.sv
// Bank of mtvec-class trap-vector CSRs: select/validity decode, read mux, write-error
// pulse and saturating violation counter around NUM_VEC lockable entries.
module e203_exu_csr_vec_bank
    import e203_csr_vec_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NUM_VEC  = 4,
    parameter int unsigned     BASE_LSB = 6,
    parameter logic [XLEN-1:0] RST_BASE = 32'h0000_0000,
    parameter int unsigned     VCNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_VEC-1:0]      i_csr_sel,
    input  logic                    i_csr_wr_en,
    input  logic                    i_csr_rd_en,
    input  logic                    i_wbck_csr_wen,
    input  logic [XLEN-1:0]         i_wbck_csr_dat,
    input  logic                    i_lock_req,
    output logic [XLEN-1:0]         o_csr_rdata,
    output logic [NUM_VEC*XLEN-1:0] o_vec_base,
    output logic [NUM_VEC*2-1:0]    o_vec_mode,
    output logic [NUM_VEC-1:0]      o_vec_locked,
    output logic                    o_wr_err,
    output logic [VCNT_W-1:0]       o_viol_cnt
);

    logic [XLEN-1:0]    w_base   [NUM_VEC];
    logic [1:0]         w_mode   [NUM_VEC];
    logic [NUM_VEC-1:0] w_locked;
    logic [NUM_VEC-1:0] w_entry_wr;
    logic               w_onehot;
    logic               w_wr_try;
    logic               w_sel_locked;
    logic               w_viol;
    logic [XLEN-1:0]    w_rdata;

    logic               r_wr_err;
    logic [VCNT_W-1:0]  r_viol_cnt;

    assign w_onehot     = is_onehot(CSR_SEL_MAX'(i_csr_sel));
    assign w_wr_try     = i_csr_wr_en & i_wbck_csr_wen & (|i_csr_sel);
    assign w_sel_locked = |(i_csr_sel & w_locked);
    assign w_viol       = w_wr_try & (~w_onehot | w_sel_locked);
    assign w_entry_wr   = (w_wr_try & w_onehot) ? (i_csr_sel & ~w_locked) : '0;

    for (genvar g = 0; g < NUM_VEC; g++) begin : g_entry
        e203_csr_vec_entry #(
            .XLEN     (XLEN),
            .BASE_LSB (BASE_LSB),
            .RST_BASE (RST_BASE)
        ) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_en    (w_entry_wr[g]),
            .i_lock_req (i_lock_req),
            .i_wdata    (i_wbck_csr_dat),
            .o_base     (w_base[g]),
            .o_mode     (w_mode[g]),
            .o_locked   (w_locked[g])
        );

        assign o_vec_base[g*XLEN +: XLEN] = w_base[g];
        assign o_vec_mode[g*2 +: 2]       = w_mode[g];
    end

    // Reads see the current register contents, so a same-cycle write returns the old value.
    always_comb begin
        w_rdata = '0;
        if (i_csr_rd_en && w_onehot) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                if (i_csr_sel[i]) begin
                    w_rdata = w_rdata | w_base[i] | {{(XLEN-2){1'b0}}, w_mode[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err   <= 1'b0;
            r_viol_cnt <= '0;
        end else begin
            r_wr_err <= w_viol;
            if (w_viol && (r_viol_cnt != {VCNT_W{1'b1}})) begin
                r_viol_cnt <= r_viol_cnt + VCNT_W'(1);
            end
        end
    end

    assign o_csr_rdata  = w_rdata;
    assign o_vec_locked = w_locked;
    assign o_wr_err     = r_wr_err;
    assign o_viol_cnt   = r_viol_cnt;

endmodule

// File: tb/tb_e203_exu_csr_vec_bank.sv
// Randomised plus directed bench: a driver pushes per-cycle expectations from a
// behavioural model; a negedge monitor pops and compares against the DUT.
module tb_e203_exu_csr_vec_bank;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NV   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NV-1:0]    csr_sel = '0;
    logic             csr_wr_en = 1'b0;
    logic             csr_rd_en = 1'b0;
    logic             wbck_csr_wen = 1'b0;
    logic [XLEN-1:0]  wbck_csr_dat = '0;
    logic             lock_req = 1'b0;
    logic [XLEN-1:0]  csr_rdata;
    logic [NV*XLEN-1:0] vec_base;
    logic [NV*2-1:0]  vec_mode;
    logic [NV-1:0]    vec_locked;
    logic             wr_err;
    logic [7:0]       viol_cnt;

    always #5 clk = ~clk;

    e203_exu_csr_vec_bank #(
        .XLEN     (XLEN),
        .NUM_VEC  (NV),
        .BASE_LSB (6),
        .RST_BASE (32'h0000_0000),
        .VCNT_W   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_csr_sel      (csr_sel),
        .i_csr_wr_en    (csr_wr_en),
        .i_csr_rd_en    (csr_rd_en),
        .i_wbck_csr_wen (wbck_csr_wen),
        .i_wbck_csr_dat (wbck_csr_dat),
        .i_lock_req     (lock_req),
        .o_csr_rdata    (csr_rdata),
        .o_vec_base     (vec_base),
        .o_vec_mode     (vec_mode),
        .o_vec_locked   (vec_locked),
        .o_wr_err       (wr_err),
        .o_viol_cnt     (viol_cnt)
    );

    typedef struct {
        logic [31:0]  rdata;
        logic         err;
        logic [7:0]   cnt;
        logic [127:0] base;
        logic [7:0]   mode;
        logic [3:0]   locked;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: architectural state of the bank.
    logic [31:0] m_base [NV];
    logic [1:0]  m_mode [NV];
    bit          m_lock [NV];
    bit          m_err;
    int          m_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_base[i] = 32'h0;
            m_mode[i] = 2'd0;
            m_lock[i] = 1'b0;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    // One clock cycle: drive inputs, record what the DUT must show this cycle, then
    // advance the model across the coming edge.
    task automatic cycle(input bit rst, input logic [3:0] sel, input bit wr, input bit wen,
                         input bit rd, input bit lk, input logic [31:0] dat);
        exp_t e;
        bit   oh;
        bit   tryw;
        bit   viol;
        int   idx;
        @(posedge clk);
        #1;
        rst_n        = rst;
        csr_sel      = sel;
        csr_wr_en    = wr;
        wbck_csr_wen = wen;
        csr_rd_en    = rd;
        lock_req     = lk;
        wbck_csr_dat = dat;
        if (!rst) model_reset();
        oh  = ($countones(sel) == 1);
        idx = 0;
        for (int i = 0; i < NV; i++) if (sel[i]) idx = i;
        e.rdata = (rd && oh) ? (m_base[idx] | {30'b0, m_mode[idx]}) : 32'h0;
        e.err   = m_err;
        e.cnt   = 8'(m_cnt);
        for (int i = 0; i < NV; i++) begin
            e.base[i*32 +: 32] = m_base[i];
            e.mode[i*2 +: 2]   = m_mode[i];
            e.locked[i]        = m_lock[i];
        end
        sb.push_back(e);
        if (rst) begin
            tryw = wr && wen && (sel != 4'b0);
            viol = tryw && (!oh || m_lock[idx]);
            if (tryw && oh && !m_lock[idx]) begin
                m_base[idx] = dat & 32'hFFFF_FFC0;
                if (dat[1:0] < 2'd2) m_mode[idx] = dat[1:0];
                if (lk) m_lock[idx] = 1'b1;
            end
            m_err = viol;
            if (viol && m_cnt < 255) m_cnt++;
        end
    endtask

    exp_t got;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("rdata",  128'(csr_rdata),  128'(got.rdata));
            chk("wr_err", 128'(wr_err),     128'(got.err));
            chk("viol",   128'(viol_cnt),   128'(got.cnt));
            chk("base",   128'(vec_base),   got.base);
            chk("mode",   128'(vec_mode),   128'(got.mode));
            chk("locked", 128'(vec_locked), 128'(got.locked));
        end
    end

    initial begin
        logic [3:0] one;
        logic [3:0] sel;
        one = 4'b0001;
        model_reset();

        cycle(0, 4'b0000, 0, 0, 0, 0, 32'h0);
        cycle(0, 4'b0001, 1, 1, 1, 0, 32'hFFFF_FFFF);
        // Basic write of entry 2, then read back every entry.
        cycle(1, 4'b0100, 1, 1, 1, 0, 32'h8000_1041);
        for (int i = 0; i < NV; i++) cycle(1, one << i, 0, 0, 1, 0, 32'h0);
        // Missing one enable term: no effect, no error.
        cycle(1, 4'b0010, 0, 1, 1, 0, 32'h1234_5641);
        cycle(1, 4'b0010, 1, 0, 1, 0, 32'h1234_5641);
        cycle(1, 4'b0010, 0, 0, 1, 0, 32'h0);
        // WARL mode on entry 0.
        cycle(1, 4'b0001, 1, 1, 1, 0, 32'h0000_2001);
        cycle(1, 4'b0001, 1, 1, 1, 0, 32'h0000_4083);
        cycle(1, 4'b0001, 1, 1, 1, 0, 32'h0000_8040);
        cycle(1, 4'b0001, 0, 0, 1, 0, 32'h0);
        // Lock entry 1, then a blocked write the very next cycle.
        cycle(1, 4'b0010, 1, 1, 1, 1, 32'h0000_1101);
        cycle(1, 4'b0010, 1, 1, 1, 0, 32'hDEAD_BEEC);
        cycle(1, 4'b0010, 0, 0, 1, 0, 32'h0);
        cycle(1, 4'b0010, 0, 0, 1, 0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) < 6) sel = one << $urandom_range(0, 3);
            else sel = 4'($urandom);
            cycle(1, sel, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0), $urandom);
        end

        // Non-one-hot writes until the counter saturates.
        for (int n = 0; n < 300; n++) cycle(1, 4'b0110, 1, 1, 1, 0, $urandom);
        cycle(1, 4'b0110, 0, 0, 1, 0, 32'h0);

        // Reset in the middle of traffic with entry 3 locked.
        cycle(1, 4'b1000, 1, 1, 1, 1, 32'h1234_5680);
        cycle(1, 4'b1000, 1, 1, 1, 0, 32'hCAFE_0001);
        cycle(0, 4'b1000, 1, 1, 1, 0, 32'hCAFE_0001);
        cycle(1, 4'b1000, 1, 1, 1, 0, 32'hCAFE_0041);
        for (int i = 0; i < NV; i++) cycle(1, one << i, 0, 0, 1, 0, 32'h0);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
